// File: rtl/cprv_lsu_stage.sv
// Load/store stage between EX and WB: in-order FIFO of in-flight ops, a decoupled
// dmem request register with lane-aligned strobes, and an extending WB register.
module cprv_lsu_stage #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int DEPTH      = 4,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_mem_i,
  output logic                  ready_mem_o,
  input  logic [6:0]            opcode_mem_i,
  input  logic [2:0]            funct3_mem_i,
  input  logic [4:0]            rd_addr_mem_i,
  input  logic                  rd_en_mem_i,
  input  logic [DATA_WIDTH-1:0] alu_out_mem_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_mem_i,
  output logic                  valid_wb_o,
  input  logic                  ready_wb_i,
  output logic [6:0]            opcode_wb_o,
  output logic [2:0]            funct3_wb_o,
  output logic [4:0]            rd_addr_wb_o,
  output logic                  rd_en_wb_o,
  output logic [DATA_WIDTH-1:0] alu_out_wb_o,
  output logic [DATA_WIDTH-1:0] mem_data_wb_o,
  output logic                  fault_wb_o,
  output logic                  valid_dmem_o,
  input  logic                  ready_dmem_i,
  output logic [ADDR_WIDTH-1:0] addr_dmem_o,
  output logic [DATA_WIDTH-1:0] wdata_dmem_o,
  output logic [STRB_WIDTH-1:0] wstrb_dmem_o,
  output logic                  w_en_dmem_o,
  input  logic                  valid_mem_dmem_i,
  output logic                  ready_mem_dmem_o,
  input  logic [DATA_WIDTH-1:0] rdata_dmem_i
);

  localparam int OFF_W = $clog2(STRB_WIDTH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef struct packed {
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [4:0]            rd;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] alu_out;
    logic                  is_mem;
    logic                  fault;
  } entry_t;

  function automatic logic [STRB_WIDTH-1:0] size_mask(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m[STRB_WIDTH-1:0];
  endfunction

  // Left-justify the accessed field, then shift back arithmetically or logically.
  function automatic logic [DATA_WIDTH-1:0] extend_load(input logic [DATA_WIDTH-1:0] d,
                                                       input logic [1:0] size,
                                                       input logic is_unsigned);
    int sh;
    logic signed [DATA_WIDTH-1:0] s;
    sh = DATA_WIDTH - (8 << size);
    if (sh <= 0) return d;
    s = d << sh;
    if (is_unsigned) return $unsigned(s) >> sh;
    return s >>> sh;
  endfunction

  logic                  is_load_in, is_store_in, is_mem_in, fault_in, misalign_in;
  logic [1:0]            size_in;
  logic [OFF_W-1:0]      off_in;
  logic [2:0]            align_m;
  logic                  req_free, accept, issue, push, pop;
  logic                  wb_free, head_valid, head_needs_rsp;
  logic [OFF_W-1:0]      head_off;
  logic [DATA_WIDTH-1:0] head_shifted;
  entry_t                entry_in, head;
  entry_t                fifo_mem [DEPTH];

  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic                  req_valid_q, req_valid_d, w_en_q, w_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  wb_valid_q, wb_valid_d, wb_rd_en_q, wb_rd_en_d, wb_fault_q, wb_fault_d;
  logic [6:0]            wb_opcode_q, wb_opcode_d;
  logic [2:0]            wb_funct3_q, wb_funct3_d;
  logic [4:0]            wb_rd_q, wb_rd_d;
  logic [DATA_WIDTH-1:0] wb_alu_q, wb_alu_d, wb_data_q, wb_data_d;

  assign is_load_in  = (opcode_mem_i == OP_LOAD);
  assign is_store_in = (opcode_mem_i == OP_STORE);
  assign is_mem_in   = is_load_in | is_store_in;
  assign size_in     = funct3_mem_i[1:0];
  assign off_in      = alu_out_mem_i[OFF_W-1:0];
  assign align_m     = 3'((1 << size_in) - 1);
  assign misalign_in = |(off_in & align_m[OFF_W-1:0]);
  assign fault_in    = is_mem_in & (misalign_in
                     | ((size_in == 2'd3) && (DATA_WIDTH == 32))
                     | (is_load_in && (funct3_mem_i == 3'b111))
                     | (is_store_in && funct3_mem_i[2]));

  assign req_free    = ~req_valid_q | ready_dmem_i;
  assign ready_mem_o = (count_q < DEPTH_C) & (~(is_mem_in & ~fault_in) | req_free);
  assign accept      = valid_mem_i & ready_mem_o;
  assign issue       = accept & is_mem_in & ~fault_in;
  assign push        = accept;

  assign entry_in = '{opcode: opcode_mem_i, funct3: funct3_mem_i, rd: rd_addr_mem_i,
                      rd_en: rd_en_mem_i, alu_out: alu_out_mem_i, is_mem: is_mem_in,
                      fault: fault_in};

  assign head           = fifo_mem[head_q];
  assign head_valid     = (count_q != '0);
  assign head_needs_rsp = head.is_mem & ~head.fault;
  assign wb_free        = ~wb_valid_q | ready_wb_i;
  assign pop            = wb_free & head_valid & (~head_needs_rsp | valid_mem_dmem_i);
  assign head_off       = head.alu_out[OFF_W-1:0];
  assign head_shifted   = rdata_dmem_i >> (8 * head_off);

  assign ready_mem_dmem_o = wb_free & head_valid & head_needs_rsp;

  always_comb begin
    req_valid_d = req_valid_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    w_en_d      = w_en_q;
    if (ready_dmem_i) req_valid_d = 1'b0;
    if (issue) begin
      req_valid_d          = 1'b1;
      addr_d               = ADDR_WIDTH'(alu_out_mem_i);
      addr_d[OFF_W-1:0]    = '0;
      wdata_d              = rs2_data_mem_i << (8 * off_in);
      wstrb_d              = is_store_in ? (size_mask(size_in) << off_in) : '1;
      w_en_d               = is_store_in;
    end

    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
    head_d  = pop  ? head_q + PTR_W'(1) : head_q;

    wb_valid_d  = wb_valid_q;
    wb_opcode_d = wb_opcode_q;
    wb_funct3_d = wb_funct3_q;
    wb_rd_d     = wb_rd_q;
    wb_rd_en_d  = wb_rd_en_q;
    wb_alu_d    = wb_alu_q;
    wb_data_d   = wb_data_q;
    wb_fault_d  = wb_fault_q;
    if (pop) begin
      wb_valid_d  = 1'b1;
      wb_opcode_d = head.opcode;
      wb_funct3_d = head.funct3;
      wb_rd_d     = head.rd;
      wb_rd_en_d  = head.rd_en & ~head.fault;
      wb_alu_d    = head.alu_out;
      wb_fault_d  = head.fault;
      wb_data_d   = (head_needs_rsp && head.opcode == OP_LOAD)
                  ? extend_load(head_shifted, head.funct3[1:0], head.funct3[2]) : '0;
    end else if (ready_wb_i) begin
      wb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[tail_q] <= entry_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      req_valid_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      w_en_q      <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_opcode_q <= '0;
      wb_funct3_q <= '0;
      wb_rd_q     <= '0;
      wb_rd_en_q  <= 1'b0;
      wb_alu_q    <= '0;
      wb_data_q   <= '0;
      wb_fault_q  <= 1'b0;
    end else begin
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      req_valid_q <= req_valid_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      w_en_q      <= w_en_d;
      wb_valid_q  <= wb_valid_d;
      wb_opcode_q <= wb_opcode_d;
      wb_funct3_q <= wb_funct3_d;
      wb_rd_q     <= wb_rd_d;
      wb_rd_en_q  <= wb_rd_en_d;
      wb_alu_q    <= wb_alu_d;
      wb_data_q   <= wb_data_d;
      wb_fault_q  <= wb_fault_d;
    end
  end

  assign valid_dmem_o  = req_valid_q;
  assign addr_dmem_o   = addr_q;
  assign wdata_dmem_o  = wdata_q;
  assign wstrb_dmem_o  = wstrb_q;
  assign w_en_dmem_o   = w_en_q;
  assign valid_wb_o    = wb_valid_q;
  assign opcode_wb_o   = wb_opcode_q;
  assign funct3_wb_o   = wb_funct3_q;
  assign rd_addr_wb_o  = wb_rd_q;
  assign rd_en_wb_o    = wb_rd_en_q;
  assign alu_out_wb_o  = wb_alu_q;
  assign mem_data_wb_o = wb_data_q;
  assign fault_wb_o    = wb_fault_q;

endmodule
